multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle opcode decoder in the CPU datapath.
- An FSM sequences each instruction through fetch, decode, execute, memory and writeback.
- Fetch, load and store wait on a memory ready handshake.
- Adds illegal-opcode trapping, build-time selectable instruction classes and a retired-instruction counter.
- Sits between the instruction register and the datapath multiplexers/enables.

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/ctrl_opdecode.sv | 38 +++
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and encodings for the multi-cycle CPU control unit:
//   - state_e     : FSM states of multicycle_control
//   - op_class_e  : instruction class produced by ctrl_opdecode
//   - OP_*        : opcode values (instruction bits [31:26])
//   - ALU_*, SRCB_*, PCSRC_* : datapath mux/ALU control encodings
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_IMM    = 3'd5,
        CLS_TRAP   = 3'd6
    } op_class_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h0C;
    localparam logic [5:0] OP_LW   = 6'h0D;
    localparam logic [5:0] OP_SW   = 6'h10;
    localparam logic [5:0] OP_BEQ  = 6'h11;
    localparam logic [5:0] OP_J    = 6'h13;
    localparam logic [5:0] OP_ORI  = 6'h1C;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_TRAP   = 2'b11;

endpackage

// File: rtl/ctrl_opdecode.sv
// ---------------------------------------------------------------------------
// ctrl_opdecode
// Combinational opcode classifier. Maps the 6-bit opcode to the instruction
// class that selects the post-DECODE state, honouring the build-time
// instruction-class enables.
// Ports:
//   opcode   in  6  instruction bits [31:26]
//   op_class out    instruction class (CLS_TRAP when not accepted)
//   legal    out 1  opcode is implemented in this build
// ---------------------------------------------------------------------------
module ctrl_opdecode
    import ctrl_pkg::*;
#(
    parameter bit HAS_JUMP    = 1'b1,
    parameter bit HAS_IMM_ALU = 1'b1
) (
    input  logic [5:0] opcode,
    output op_class_e  op_class,
    output logic       legal
);

    always_comb begin
        op_class = CLS_TRAP;
        case (opcode)
            OP_R:    op_class = CLS_R;
            OP_LW:   op_class = CLS_LOAD;
            OP_SW:   op_class = CLS_STORE;
            OP_BEQ:  op_class = CLS_BRANCH;
            OP_J:    op_class = HAS_JUMP ? CLS_JUMP : CLS_TRAP;
            OP_ADDI,
            OP_ORI:  op_class = HAS_IMM_ALU ? CLS_IMM : CLS_TRAP;
            default: op_class = CLS_TRAP;
        endcase
    end

    assign legal = (op_class != CLS_TRAP);

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multi-cycle CPU control FSM: FETCH -> DECODE -> (EXEC/MEM/BRANCH/JUMP/TRAP)
// -> ... -> FETCH, with memory-ready waits in FETCH, MEM_RD and MEM_WR, an
// illegal-opcode trap and a retired-instruction counter.
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   opcode     in   IR[31:26], looked at only in DECODE and EXEC_I
//   mem_ready  in   memory finishes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
//   pc_source  out  datapath controls (decoded from state)
//   illegal    out  one-cycle pulse while in TRAP
//   retired    out  completed-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter bit HAS_JUMP    = 1'b1,
    parameter bit HAS_IMM_ALU = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state;
    state_e           state_next;
    op_class_e        op_class;
    logic             op_legal;
    logic             is_store;   // LW/SW choice captured in DECODE
    logic             retire;
    logic [CNT_W-1:0] retired_q;

    ctrl_opdecode #(
        .HAS_JUMP    (HAS_JUMP),
        .HAS_IMM_ALU (HAS_IMM_ALU)
    ) u_opdecode (
        .opcode   (opcode),
        .op_class (op_class),
        .legal    (op_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            is_store  <= 1'b0;
            retired_q <= '0;
        end else begin
            state <= state_next;
            // MEM_ADDR must not look at opcode, so remember the access type here.
            if (state == S_DECODE) begin
                is_store <= (op_class == CLS_STORE);
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign retired = retired_q;

    always_comb begin
        state_next    = state;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        illegal       = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // IR and PC+4 are committed only on the cycle memory delivers.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b = SRCB_IMM_SH2;
                if (!op_legal) begin
                    state_next = S_TRAP;
                end else begin
                    case (op_class)
                        CLS_R:                state_next = S_EXEC_R;
                        CLS_LOAD, CLS_STORE:  state_next = S_MEM_ADDR;
                        CLS_BRANCH:           state_next = S_BRANCH;
                        CLS_JUMP:             state_next = S_JUMP;
                        CLS_IMM:              state_next = S_EXEC_I;
                        default:              state_next = S_TRAP;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_FUNCT;
                state_next = S_WB_R;
            end
            S_WB_R: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
                state_next = S_WB_I;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = is_store ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_next = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire        = 1'b1;
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_TRAP;
                illegal    = 1'b1;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control. Three instances:
//   a : default build (CNT_W=32)
//   b : HAS_JUMP=0, CNT_W=4   (shares stimulus with a)
//   c : HAS_IMM_ALU=0         (own opcode/mem_ready)
// Control outputs are packed into a 17-bit vector per instance:
//   {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//    alu_op[1:0], pc_source[1:0], illegal}
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [5:0] T_R    = 6'h00;
    localparam logic [5:0] T_ADDI = 6'h0C;
    localparam logic [5:0] T_LW   = 6'h0D;
    localparam logic [5:0] T_SW   = 6'h10;
    localparam logic [5:0] T_BEQ  = 6'h11;
    localparam logic [5:0] T_J    = 6'h13;
    localparam logic [5:0] T_ORI  = 6'h1C;
    localparam logic [5:0] T_BAD  = 6'h3F;

    // Expected control vectors per state, written out from the state table.
    localparam logic [16:0] V_FR   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0; // FETCH, ready
    localparam logic [16:0] V_FW   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0; // FETCH, waiting
    localparam logic [16:0] V_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] V_EXR  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] V_WBR  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] V_EXIA = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0; // EXEC_I ADDI
    localparam logic [16:0] V_EXIO = 17'b0_0_0_0_0_0_0_0_0_1_10_11_00_0; // EXEC_I ORI
    localparam logic [16:0] V_WBI  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] V_MA   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] V_MRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] V_WBM  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] V_MWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] V_BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] V_JMP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] V_TRAP = 17'b1_0_0_0_0_0_0_0_0_0_00_00_11_1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [5:0]  c_opcode;
    logic        c_ready;

    logic [16:0] a_ctl, b_ctl, c_ctl;
    logic [31:0] a_retired;
    logic [3:0]  b_retired;
    logic [31:0] c_retired;

    int checks = 0;
    int errors = 0;
    int exp_a  = 0;
    int exp_b  = 0;
    int exp_c  = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(a_ctl[16]), .pc_write_cond(a_ctl[15]), .i_or_d(a_ctl[14]),
        .mem_read(a_ctl[13]), .mem_write(a_ctl[12]), .ir_write(a_ctl[11]),
        .mem_to_reg(a_ctl[10]), .reg_dst(a_ctl[9]), .reg_write(a_ctl[8]),
        .alu_src_a(a_ctl[7]), .alu_src_b(a_ctl[6:5]), .alu_op(a_ctl[4:3]),
        .pc_source(a_ctl[2:1]), .illegal(a_ctl[0]), .retired(a_retired)
    );

    multicycle_control #(.CNT_W(4), .HAS_JUMP(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(b_ctl[16]), .pc_write_cond(b_ctl[15]), .i_or_d(b_ctl[14]),
        .mem_read(b_ctl[13]), .mem_write(b_ctl[12]), .ir_write(b_ctl[11]),
        .mem_to_reg(b_ctl[10]), .reg_dst(b_ctl[9]), .reg_write(b_ctl[8]),
        .alu_src_a(b_ctl[7]), .alu_src_b(b_ctl[6:5]), .alu_op(b_ctl[4:3]),
        .pc_source(b_ctl[2:1]), .illegal(b_ctl[0]), .retired(b_retired)
    );

    multicycle_control #(.CNT_W(32), .HAS_IMM_ALU(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .opcode(c_opcode), .mem_ready(c_ready),
        .pc_write(c_ctl[16]), .pc_write_cond(c_ctl[15]), .i_or_d(c_ctl[14]),
        .mem_read(c_ctl[13]), .mem_write(c_ctl[12]), .ir_write(c_ctl[11]),
        .mem_to_reg(c_ctl[10]), .reg_dst(c_ctl[9]), .reg_write(c_ctl[8]),
        .alu_src_a(c_ctl[7]), .alu_src_b(c_ctl[6:5]), .alu_op(c_ctl[4:3]),
        .pc_source(c_ctl[2:1]), .illegal(c_ctl[0]), .retired(c_retired)
    );

    // Drivers: change inputs on the falling edge, let them settle for 1ns.
    task automatic drive(input logic [5:0] op, input logic rdy);
        @(negedge clk);
        opcode    = op;
        mem_ready = rdy;
        #1;
    endtask

    task automatic drive_c(input logic [5:0] op, input logic rdy);
        @(negedge clk);
        c_opcode = op;
        c_ready  = rdy;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; opcode = T_R; c_opcode = T_R; c_ready = 1'b0;
        #2;
        checks++;
        if (a_ctl !== V_FW) begin
            errors++; $display("FAIL reset_ctl_a got %b want %b", a_ctl, V_FW);
        end
        checks++;
        if (a_retired !== 32'd0 || b_retired !== 4'd0 || c_retired !== 32'd0) begin
            errors++; $display("FAIL reset_retired got %0d/%0d/%0d want 0", a_retired, b_retired, c_retired);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (a_ctl !== V_FR) begin
            errors++; $display("FAIL reset_fetch_gate got %b want %b", a_ctl, V_FR);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        exp_a = 0; exp_b = 0; exp_c = 0;
    endtask

    task automatic test_r_type();
        logic [16:0] ev [4] = '{V_FR, V_DEC, V_EXR, V_WBR};
        for (int i = 0; i < 4; i++) begin
            drive(T_R, 1'b1);
            checks++;
            if (a_ctl !== ev[i] || b_ctl !== ev[i]) begin
                errors++; $display("FAIL r_type cyc%0d got %b/%b want %b", i, a_ctl, b_ctl, ev[i]);
            end
        end
        drive(T_R, 1'b0);
        exp_a++; exp_b++;
        checks++;
        if (a_retired !== 32'(exp_a) || b_retired !== 4'(exp_b) || a_ctl !== V_FW) begin
            errors++; $display("FAIL r_type_retire got %0d/%0d ctl %b want %0d/%0d", a_retired, b_retired, a_ctl, exp_a, exp_b);
        end
    endtask

    task automatic test_load();
        // Opcode is SW everywhere except DECODE; MEM_ADDR must still pick MEM_RD.
        logic [5:0]  ops [10] = '{T_SW, T_SW, T_SW, T_LW, T_SW, T_SW, T_SW, T_SW, T_SW, T_SW};
        logic        rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [16:0] ev  [10] = '{V_FW, V_FW, V_FR, V_DEC, V_MA, V_MRD, V_MRD, V_MRD, V_MRD, V_WBM};
        int irw = 0;
        int rgw = 0;
        for (int i = 0; i < 10; i++) begin
            drive(ops[i], rdy[i]);
            irw += int'(a_ctl[11]);
            rgw += int'(a_ctl[8]);
            checks++;
            if (a_ctl !== ev[i] || b_ctl !== ev[i]) begin
                errors++; $display("FAIL load cyc%0d got %b/%b want %b", i, a_ctl, b_ctl, ev[i]);
            end
        end
        checks++;
        if (irw != 1 || rgw != 1) begin
            errors++; $display("FAIL load_pulses ir_write=%0d reg_write=%0d want 1/1", irw, rgw);
        end
        drive(T_BAD, 1'b0);
        exp_a++; exp_b++;
        checks++;
        if (a_retired !== 32'(exp_a) || b_retired !== 4'(exp_b) || a_ctl !== V_FW) begin
            errors++; $display("FAIL load_retire got %0d/%0d ctl %b want %0d/%0d", a_retired, b_retired, a_ctl, exp_a, exp_b);
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0]  ops [6] = '{T_BAD, T_BEQ, T_BAD, T_BAD, T_J, T_BAD};
        logic [16:0] ea  [6] = '{V_FR, V_DEC, V_BR, V_FR, V_DEC, V_JMP};
        logic [16:0] eb  [6] = '{V_FR, V_DEC, V_BR, V_FR, V_DEC, V_TRAP};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], 1'b1);
            checks++;
            if (a_ctl !== ea[i]) begin
                errors++; $display("FAIL beq_j_a cyc%0d got %b want %b", i, a_ctl, ea[i]);
            end
            checks++;
            if (b_ctl !== eb[i]) begin
                errors++; $display("FAIL beq_j_nojump cyc%0d got %b want %b", i, b_ctl, eb[i]);
            end
        end
        drive(T_BAD, 1'b0);
        exp_a += 2; exp_b += 1;
        checks++;
        if (a_retired !== 32'(exp_a) || b_retired !== 4'(exp_b)) begin
            errors++; $display("FAIL beq_j_retire got %0d/%0d want %0d/%0d", a_retired, b_retired, exp_a, exp_b);
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  ops [3] = '{T_R, T_BAD, T_R};
        logic [16:0] ev  [3] = '{V_FR, V_DEC, V_TRAP};
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], 1'b1);
            checks++;
            if (a_ctl !== ev[i] || b_ctl !== ev[i]) begin
                errors++; $display("FAIL illegal cyc%0d got %b/%b want %b", i, a_ctl, b_ctl, ev[i]);
            end
        end
        drive(T_R, 1'b0);
        checks++;
        if (a_ctl !== V_FW || a_retired !== 32'(exp_a) || b_retired !== 4'(exp_b)) begin
            errors++; $display("FAIL illegal_after ctl %b retired %0d/%0d want %b %0d/%0d", a_ctl, a_retired, b_retired, V_FW, exp_a, exp_b);
        end
    endtask

    task automatic test_store();
        logic [5:0]  ops [5] = '{T_R, T_SW, T_LW, T_LW, T_LW};
        logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [16:0] ev  [5] = '{V_FR, V_DEC, V_MA, V_MWR, V_MWR};
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], rdy[i]);
            checks++;
            if (a_ctl !== ev[i] || b_ctl !== ev[i]) begin
                errors++; $display("FAIL store cyc%0d got %b/%b want %b", i, a_ctl, b_ctl, ev[i]);
            end
        end
        drive(T_R, 1'b0);
        exp_a++; exp_b++;
        checks++;
        if (a_retired !== 32'(exp_a) || b_retired !== 4'(exp_b) || a_ctl !== V_FW) begin
            errors++; $display("FAIL store_retire got %0d/%0d ctl %b want %0d/%0d", a_retired, b_retired, a_ctl, exp_a, exp_b);
        end
    endtask

    task automatic test_reset_in_mem_wr();
        logic [5:0]  ops [4] = '{T_R, T_SW, T_R, T_R};
        logic        rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [16:0] ev  [4] = '{V_FR, V_DEC, V_MA, V_MWR};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], rdy[i]);
            checks++;
            if (a_ctl !== ev[i]) begin
                errors++; $display("FAIL rst_mwr cyc%0d got %b want %b", i, a_ctl, ev[i]);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (a_ctl !== V_FW || b_ctl !== V_FW) begin
            errors++; $display("FAIL rst_mwr_ctl got %b/%b want %b", a_ctl, b_ctl, V_FW);
        end
        checks++;
        if (a_retired !== 32'd0 || b_retired !== 4'd0 || c_retired !== 32'd0) begin
            errors++; $display("FAIL rst_mwr_retired got %0d/%0d/%0d want 0", a_retired, b_retired, c_retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_a = 0; exp_b = 0; exp_c = 0;
    endtask

    task automatic test_imm_wrap();
        logic [5:0]  ops [4] = '{T_R, T_ADDI, T_ADDI, T_R};
        logic [16:0] ev  [4] = '{V_FR, V_DEC, V_EXIA, V_WBI};
        logic [5:0]  opo [4] = '{T_R, T_ORI, T_ORI, T_R};
        logic [16:0] evo [4] = '{V_FR, V_DEC, V_EXIO, V_WBI};
        for (int n = 0; n < 17; n++) begin
            for (int i = 0; i < 4; i++) begin
                drive(ops[i], 1'b1);
                checks++;
                if (a_ctl !== ev[i] || b_ctl !== ev[i]) begin
                    errors++; $display("FAIL addi n%0d cyc%0d got %b/%b want %b", n, i, a_ctl, b_ctl, ev[i]);
                end
            end
            exp_a++; exp_b++;
        end
        drive(T_R, 1'b0);
        checks++;
        if (b_retired !== 4'd1 || b_retired !== 4'(exp_b)) begin
            errors++; $display("FAIL wrap_cnt4 got %0d want 1", b_retired);
        end
        checks++;
        if (a_retired !== 32'd17) begin
            errors++; $display("FAIL wrap_cnt32 got %0d want 17", a_retired);
        end
        for (int i = 0; i < 4; i++) begin
            drive(opo[i], 1'b1);
            checks++;
            if (a_ctl !== evo[i]) begin
                errors++; $display("FAIL ori cyc%0d got %b want %b", i, a_ctl, evo[i]);
            end
        end
        drive(T_R, 1'b0);
        exp_a++; exp_b++;
        checks++;
        if (a_retired !== 32'd18 || b_retired !== 4'd2) begin
            errors++; $display("FAIL ori_retire got %0d/%0d want 18/2", a_retired, b_retired);
        end
    endtask

    task automatic test_imm_disabled();
        logic [5:0]  ops [10] = '{T_R, T_ADDI, T_R, T_R, T_ORI, T_ORI, T_R, T_R, T_R, T_R};
        logic [16:0] ev  [10] = '{V_FR, V_DEC, V_TRAP, V_FR, V_DEC, V_TRAP, V_FR, V_DEC, V_EXR, V_WBR};
        for (int i = 0; i < 10; i++) begin
            drive_c(ops[i], 1'b1);
            checks++;
            if (c_ctl !== ev[i]) begin
                errors++; $display("FAIL noimm cyc%0d got %b want %b", i, c_ctl, ev[i]);
            end
        end
        drive_c(T_R, 1'b0);
        exp_c++;
        checks++;
        if (c_retired !== 32'(exp_c) || c_ctl !== V_FW) begin
            errors++; $display("FAIL noimm_retire got %0d ctl %b want %0d", c_retired, c_ctl, exp_c);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_r_type();
        test_load();
        test_branch_jump();
        test_illegal();
        test_store();
        test_reset_in_mem_wr();
        test_imm_wrap();
        test_imm_disabled();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
